hyperbus_tf_split: RTL and testbench



---
 rtl/hyperbus_tf_split.sv | 159 +++++++++++++++
 tb/tb_hyperbus_tf_split.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_tf_split.sv
// Splits one front-end request into PHY transfers bounded by max burst and BoundaryWords alignment.
// Optional split-statistics counter enabled by HYPERBUS_TF_SPLIT_STATS_EN.
module hyperbus_tf_split #(
  parameter int AddrWidth     = 32,
  parameter int BurstWidth    = 16,
  parameter int NumChips      = 2,
  parameter int BoundaryWords = 512
) (
  input  logic                  clk_0_i,
  input  logic                  rst_ni,
  input  logic [BurstWidth-1:0] cfg_max_burst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [AddrWidth-1:0]  in_addr_i,
  input  logic [BurstWidth-1:0] in_len_i,
  input  logic                  in_write_i,
  input  logic                  in_addr_space_i,
  input  logic [NumChips-1:0]   in_cs_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [AddrWidth-1:0]  out_addr_o,
  output logic [BurstWidth-1:0] out_burst_o,
  output logic                  out_write_o,
  output logic                  out_addr_space_o,
  output logic [NumChips-1:0]   out_cs_o,
  output logic                  out_last_o,
  output logic                  zero_len_o,
`ifdef HYPERBUS_TF_SPLIT_STATS_EN
  input  logic                  stat_clear_i,
  output logic [15:0]           stat_splits_o,
`endif
  output logic                  busy_o
);

  localparam int OffW = $clog2(BoundaryWords);
  localparam int CW   = BurstWidth + 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [BurstWidth-1:0] rem_q, rem_d;
  logic [BurstWidth-1:0] max_q, max_d;
  logic                  write_q, write_d;
  logic                  space_q, space_d;
  logic [NumChips-1:0]   cs_q, cs_d;
  logic                  zero_len_q, zero_len_d;
  logic                  split_q, split_d;

  logic [CW-1:0] to_bound;
  logic [CW-1:0] chunk;
  logic          issue;
  logic          last;
  logic          hs;

  always_comb begin
    to_bound = CW'(BoundaryWords) - CW'(addr_q[OffW-1:0]);
    chunk    = CW'(rem_q);
    if (to_bound < chunk) chunk = to_bound;
    if ((max_q != '0) && (CW'(max_q) < chunk)) chunk = CW'(max_q);
  end

  assign issue = (state_q == ISSUE);
  assign last  = (chunk == CW'(rem_q));
  assign hs    = issue & out_ready_i;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    max_d      = max_q;
    write_d    = write_q;
    space_d    = space_q;
    cs_d       = cs_q;
    split_d    = split_q;
    zero_len_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (in_len_i != '0) begin
            addr_d  = in_addr_i;
            rem_d   = in_len_i;
            max_d   = cfg_max_burst_i;
            write_d = in_write_i;
            space_d = in_addr_space_i;
            cs_d    = in_cs_i;
            split_d = 1'b0;
            state_d = ISSUE;
          end else begin
            zero_len_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (hs) begin
          addr_d = addr_q + AddrWidth'(chunk);
          rem_d  = rem_q - chunk[BurstWidth-1:0];
          if (last) state_d = IDLE;
          else      split_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_0_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      max_q      <= '0;
      write_q    <= 1'b0;
      space_q    <= 1'b0;
      cs_q       <= '0;
      zero_len_q <= 1'b0;
      split_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      max_q      <= max_d;
      write_q    <= write_d;
      space_q    <= space_d;
      cs_q       <= cs_d;
      zero_len_q <= zero_len_d;
      split_q    <= split_d;
    end
  end

  // Fields are forced to zero outside Issue so idle outputs match the reset state.
  assign in_ready_o       = ~issue;
  assign busy_o           = issue;
  assign out_valid_o      = issue;
  assign out_addr_o       = issue ? addr_q : '0;
  assign out_burst_o      = issue ? chunk[BurstWidth-1:0] : '0;
  assign out_write_o      = issue & write_q;
  assign out_addr_space_o = issue & space_q;
  assign out_cs_o         = issue ? cs_q : '0;
  assign out_last_o       = issue & last;
  assign zero_len_o       = zero_len_q;

`ifdef HYPERBUS_TF_SPLIT_STATS_EN
  logic [15:0] splits_q, splits_d;

  always_comb begin
    splits_d = splits_q;
    if (stat_clear_i)                                        splits_d = '0;
    else if (hs && last && split_q && (splits_q != 16'hFFFF)) splits_d = splits_q + 16'd1;
  end

  always_ff @(posedge clk_0_i or negedge rst_ni) begin
    if (!rst_ni) splits_q <= '0;
    else         splits_q <= splits_d;
  end

  assign stat_splits_o = splits_q;
`endif

endmodule

// File: tb/tb_hyperbus_tf_split.sv
// Directed bench for hyperbus_tf_split: split rules, backpressure, zero length, wrap and reset.
module tb_hyperbus_tf_split;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_max;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [15:0] in_len;
  logic        in_write;
  logic        in_space;
  logic [1:0]  in_cs;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [15:0] out_burst;
  logic        out_write;
  logic        out_space;
  logic [1:0]  out_cs;
  logic        out_last;
  logic        zero_len;
  logic        busy;
`ifdef HYPERBUS_TF_SPLIT_STATS_EN
  logic        stat_clear;
  logic [15:0] stat_splits;
`endif

  int total = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  hyperbus_tf_split dut (
    .clk_0_i          (clk),
    .rst_ni           (rst_n),
    .cfg_max_burst_i  (cfg_max),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_addr_i        (in_addr),
    .in_len_i         (in_len),
    .in_write_i       (in_write),
    .in_addr_space_i  (in_space),
    .in_cs_i          (in_cs),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_addr_o       (out_addr),
    .out_burst_o      (out_burst),
    .out_write_o      (out_write),
    .out_addr_space_o (out_space),
    .out_cs_o         (out_cs),
    .out_last_o       (out_last),
    .zero_len_o       (zero_len),
`ifdef HYPERBUS_TF_SPLIT_STATS_EN
    .stat_clear_i     (stat_clear),
    .stat_splits_o    (stat_splits),
`endif
    .busy_o           (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; all driving and sampling happens 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [15:0] l, input logic [15:0] m);
    in_valid = 1'b1;
    in_addr  = a;
    in_len   = l;
    cfg_max  = m;
    chk("accept_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  // Checks the currently presented transfer, then lets it handshake.
  task automatic xfer(input string tag, input logic [31:0] a, input logic [15:0] b, input logic l);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_addr"},  out_addr,  a);
    chk({tag, "_burst"}, out_burst, b);
    chk({tag, "_last"},  out_last,  l);
    chk({tag, "_busy"},  busy,      1);
    chk({tag, "_ready"}, in_ready,  0);
    step();
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    cfg_max   = '0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_len    = '0;
    in_write  = 1'b1;
    in_space  = 1'b0;
    in_cs     = 2'b10;
    out_ready = 1'b1;
`ifdef HYPERBUS_TF_SPLIT_STATS_EN
    stat_clear = 1'b0;
`endif
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_zl", zero_len, 0);
    chk("rst_burst", out_burst, 0);
    step();
    rst_n = 1'b1;
    step();

    // No split
    send(32'h10, 16'd8, 16'd0);
    chk("ns_write", out_write, 1);
    chk("ns_cs", out_cs, 2'b10);
    xfer("ns", 32'h10, 16'd8, 1'b1);
    chk("ns_idle_busy", busy, 0);
    chk("ns_idle_valid", out_valid, 0);

    // Boundary split
    send(32'h1FC, 16'd10, 16'd0);
    xfer("bd0", 32'h1FC, 16'd4, 1'b0);
    xfer("bd1", 32'h200, 16'd6, 1'b1);
`ifdef HYPERBUS_TF_SPLIT_STATS_EN
    chk("stat_bd", stat_splits, 1);
`endif

    // Max-burst split, config change mid-request ignored
    send(32'h0, 16'd20, 16'd8);
    cfg_max = 16'd2;
    xfer("mx0", 32'h0,  16'd8, 1'b0);
    xfer("mx1", 32'h8,  16'd8, 1'b0);
    xfer("mx2", 32'h10, 16'd4, 1'b1);

    // Backpressure on the second transfer
    send(32'h0, 16'd20, 16'd8);
    xfer("bp0", 32'h0, 16'd8, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_addr", out_addr, 32'h8);
      chk("bp_hold_burst", out_burst, 16'd8);
      chk("bp_hold_last", out_last, 0);
      chk("bp_hold_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    xfer("bp1", 32'h8, 16'd8, 1'b0);
    // A new request waiting during the last handshake is taken only after the bubble
    in_valid = 1'b1;
    in_addr  = 32'hFFFF_FFFE;
    in_len   = 16'd4;
    cfg_max  = 16'd0;
    xfer("bp2", 32'h10, 16'd4, 1'b1);
    chk("bubble_valid", out_valid, 0);
    chk("bubble_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    // Address wrap
    xfer("wr0", 32'hFFFF_FFFE, 16'd2, 1'b0);
    xfer("wr1", 32'h0, 16'd2, 1'b1);
`ifdef HYPERBUS_TF_SPLIT_STATS_EN
    chk("stat_wr", stat_splits, 4);
`endif

    // Zero length
    send(32'h40, 16'd0, 16'd0);
    chk("zl_pulse", zero_len, 1);
    chk("zl_valid", out_valid, 0);
    chk("zl_ready", in_ready, 1);
    step();
    chk("zl_clear", zero_len, 0);
    chk("zl_valid2", out_valid, 0);

    // Reset mid-request
    send(32'h0, 16'd20, 16'd8);
    xfer("rs0", 32'h0, 16'd8, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rs_valid", out_valid, 0);
    chk("rs_burst", out_burst, 0);
    chk("rs_addr", out_addr, 0);
    chk("rs_busy", busy, 0);
    step();
    rst_n = 1'b1;
    chk("rs_ready", in_ready, 1);
`ifdef HYPERBUS_TF_SPLIT_STATS_EN
    chk("rs_stat", stat_splits, 0);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rs_no_residual", out_valid, 0);
      chk("rs_ready_after", in_ready, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, errs);
    $finish;
  end

endmodule
